wq_mem_arbiter: RTL
===================

# wq_mem_arbiter

Single-port memory arbiter that shares the RAM bus between instruction fetches, data-cache miss fills and drains from the data-cache write queue. It sits between the caches, the write queue FIFO and the RAM. It sequences one RAM transaction at a time and issues the queue's pop strobe only when a drain write completes. It guarantees write-queue drains cannot starve, and that a miss fill never reads stale data at the address held in the queue head.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive non-drain grants tolerated while the queue is non-empty (1..15)

- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous reset, active-high (asserted = 1)
- iREN  in  1  instruction fetch request
- iaddr  in  ADDR_W  fetch address
- iwait  out  1  low for exactly the cycle fetch data is valid
- iload  out  DATA_W  fetch data (ramload passthrough)
- dmissREN  in  1  dcache miss fill request
- dmissaddr  in  ADDR_W  fill address
- dwait  out  1  low for exactly the cycle fill data is valid
- dload  out  DATA_W  fill data (ramload passthrough)
- wempty  in  1  write queue empty
- full  in  1  write queue full
- wdaddr  in  ADDR_W  queue head address
- dstore  in  DATA_W  queue head data
- wq_pop  out  1  one-cycle FIFO read strobe
- ramREN, ramWEN  out  1  RAM read / write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ram_ready  in  1  RAM completes the current access this cycle

## Operation
- FSM states: IDLE, IFETCH, DFILL, DRAIN. Only one state is active per cycle.
- IDLE grant priority, evaluated each cycle. The winning state is entered next cycle.
  1. DRAIN when !wempty and (starve_cnt == STARVE_MAX, or dmissREN with dmissaddr == wdaddr).
  2. DFILL when dmissREN.
  3. DRAIN when full.
  4. IFETCH when iREN.
  5. DRAIN when !wempty.
  6. Otherwise stay in IDLE.
- On grant, the address is latched into addr_q. For DRAIN, dstore is also latched into data_q. ramaddr = addr_q in every non-IDLE state.
- IFETCH/DFILL:
  - ramREN=1.
  - On ram_ready, the matching wait is 0 for that cycle and load = ramload; next state IDLE.
  - If the requester drops REN before ram_ready, go to IDLE next cycle with no wait pulse.
- DRAIN:
  - ramWEN=1, ramstore = data_q.
  - On ram_ready, wq_pop=1 for that cycle; next state IDLE.
  - A drain is never aborted.
- starve_cnt (4 bits):
  - Cleared when wempty or when a DRAIN completes.
  - Otherwise incremented on each completed IFETCH/DFILL, saturating at STARVE_MAX.
- iwait/dwait are 1 in every cycle not described above. wq_pop is 0 outside DRAIN completion.

## Timing
- Reset values:
  - state=IDLE, starve_cnt=0, addr_q=0, data_q=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=1, dwait=1, wq_pop=0.
  - iload/dload follow ramload.
- Reset is asynchronous. An in-flight transaction is abandoned with no pop and no wait pulse.
- Minimum latency: request in cycle 0 (IDLE), RAM enables in cycle 1. With ram_ready in cycle 1, wait is low in cycle 1. Completion takes 2 cycles.
- Back-to-back transactions: every transaction returns through one IDLE cycle. The peak is one access per 2 cycles.
- RAM enables are registered-state decodes (Moore). Waits, pop and loads are combinational on ram_ready.
- Simultaneous grant and FIFO write (queue becomes non-empty in the same cycle): the queue flags are sampled as presented. A new entry is considered in the next IDLE cycle.
- Head-address match is exact ADDR_W equality, with no byte masking.

## Test plan
- Reset: assert n_rst mid-DFILL -> outputs return to reset values immediately. After release with dmissREN=1, DFILL restarts and ramREN=1 one cycle later.
- Fetch only: iREN, iaddr=0x40, ram_ready after 3 cycles, ramload=0xDEADBEEF -> ramaddr=0x40, iwait=0 for exactly 1 cycle with iload=0xDEADBEEF.
- Priority: iREN, dmissREN and !wempty (not full) together -> order DFILL, IFETCH, DRAIN. Exactly one wq_pop, coincident with ram_ready in DRAIN.
- Hazard: wdaddr=dmissaddr=0x100, !wempty -> DRAIN (ramWEN, ramaddr=0x100) completes before DFILL reads 0x100.
- Starvation: STARVE_MAX=4, queue non-empty, iREN held high -> after 4 completed IFETCHes the next grant is DRAIN and starve_cnt returns to 0.
- Abort: iREN dropped 1 cycle after grant, ram_ready never asserted -> IDLE next cycle, iwait stays 1, no pop.

Source files
------------

// File: rtl/wq_mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its neighbours: the instruction
// cache, the data-cache miss path, the write-queue FIFO head and the RAM.
//
// Parameters: ADDR_W address width, DATA_W data width.
// Modports:
//   master - the arbiter's view. It drives the RAM enables, address and store
//            data, the iwait/dwait handshakes, the load passthroughs and the
//            queue pop strobe.
//   slave  - the environment's view (caches, write queue, RAM).
interface wq_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction fetch port
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;

    // data-cache miss fill port
    logic              dmissREN;
    logic [ADDR_W-1:0] dmissaddr;
    logic              dwait;
    logic [DATA_W-1:0] dload;

    // write queue head and status
    logic              wempty;
    logic              full;
    logic [ADDR_W-1:0] wdaddr;
    logic [DATA_W-1:0] dstore;
    logic              wq_pop;

    // single-port RAM
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ram_ready;

    modport master (
        input  iREN, iaddr, dmissREN, dmissaddr,
        input  wempty, full, wdaddr, dstore,
        input  ramload, ram_ready,
        output iwait, iload, dwait, dload, wq_pop,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dmissREN, dmissaddr,
        output wempty, full, wdaddr, dstore,
        output ramload, ram_ready,
        input  iwait, iload, dwait, dload, wq_pop,
        input  ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/wq_mem_arbiter.sv
// Single-port RAM arbiter shared by instruction fetches, data-cache miss
// fills and write-queue drains. One RAM transaction runs at a time and every
// transaction returns through an IDLE cycle where the next grant is chosen.
// Drains cannot starve (starve_cnt forces one after STARVE_MAX other
// completions) and a fill whose address equals the queue head waits until
// that head has been written back.
//
// Ports:
//   clk   - system clock, rising edge
//   n_rst - asynchronous reset, active-high despite its name
//   bus   - wq_mem_arbiter_if master modport (caches, write queue, RAM)
//
// Parameters: ADDR_W, DATA_W, STARVE_MAX (1..15).
module wq_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    wq_mem_arbiter_if.master  bus
);

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, IFETCH, DFILL, DRAIN} state_t;

    state_t            state;
    state_t            next_state;
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] grant_addr;
    logic              hazard;
    logic              starved;
    logic              read_done;
    logic              drain_done;

    // A fill that hits the queue head must see the drained data first.
    assign hazard     = bus.dmissREN && (bus.dmissaddr == bus.wdaddr);
    assign starved    = (starve_cnt == STARVE_LIMIT);
    assign read_done  = ((state == IFETCH) || (state == DFILL)) && bus.ram_ready;
    assign drain_done = (state == DRAIN) && bus.ram_ready;

    // Loads are pure passthroughs; the wait strobes say when they are valid.
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

    // State register.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant selection in IDLE, plus Moore RAM enables and the combinational
    // completion strobes while a transaction is in flight.
    always_comb begin
        next_state   = state;
        grant_addr   = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.wq_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.wempty && (starved || hazard)) begin
                    next_state = DRAIN;
                    grant_addr = bus.wdaddr;
                end else if (bus.dmissREN) begin
                    next_state = DFILL;
                    grant_addr = bus.dmissaddr;
                end else if (bus.full) begin
                    next_state = DRAIN;
                    grant_addr = bus.wdaddr;
                end else if (bus.iREN) begin
                    next_state = IFETCH;
                    grant_addr = bus.iaddr;
                end else if (!bus.wempty) begin
                    next_state = DRAIN;
                    grant_addr = bus.wdaddr;
                end
            end
            IFETCH: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = addr_q;
                if (bus.ram_ready) begin
                    bus.iwait  = 1'b0;
                    next_state = IDLE;
                end else if (!bus.iREN) begin
                    next_state = IDLE;
                end
            end
            DFILL: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = addr_q;
                if (bus.ram_ready) begin
                    bus.dwait  = 1'b0;
                    next_state = IDLE;
                end else if (!bus.dmissREN) begin
                    next_state = IDLE;
                end
            end
            DRAIN: begin
                // A drain always runs to completion so the pop stays paired
                // with a real write.
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = addr_q;
                bus.ramstore = data_q;
                if (bus.ram_ready) begin
                    bus.wq_pop = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture the winning address (and store data for a drain) on grant so
    // the requester is free to move on while the RAM works.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else if ((state == IDLE) && (next_state != IDLE)) begin
            addr_q <= grant_addr;
            if (next_state == DRAIN) begin
                data_q <= bus.dstore;
            end
        end
    end

    // Count reads completed while the queue waits; saturates at the limit.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            starve_cnt <= '0;
        end else if (bus.wempty || drain_done) begin
            starve_cnt <= '0;
        end else if (read_done && !starved) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule
